move_controller: RTL and testbench
==================================

# move_controller

Turn sequencer and move validator for the tic-tac-toe datapath. Accepts a player's square selection, checks it against the current board read back from the position register bank, then issues either a one-cycle write-enable to that bank or a one-cycle illegal-move flag. After each accepted move it evaluates the board for a win or a draw and alternates the turn. It is the initiator side of the `ply_En_pos` / `illegal_move` / `XO_turn` interface consumed by the position registers.

## Interface
- No parameters; board size is fixed at 3x3.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; shared with the position register bank.
- `play` in 1: move request; only its rising edge counts.
- `position` in 4: requested square, 1..9 (row-major); 0 and 10..15 are illegal.
- `pos1`..`pos9` in 2 each: current cells from the register bank; 00 empty, 01 X, 10 O, 11 treated as occupied.
- `ply_En_pos` out 9: one-hot write enable; bit k-1 selects square k.
- `illegal_move` out 1: one-cycle reject pulse.
- `XO_turn` out 1: 1 means X to move (bank writes 01); 0 means O to move (bank writes 10).
- `game_over` out 1: sticky end-of-game flag.
- `winner` out 2: 00 none, 01 X, 10 O, 11 draw.
- `move_count` out 4: number of accepted moves, 0..9.

## Operation
- Reset values: state IDLE, `ply_En_pos`=0, `illegal_move`=0, `XO_turn`=1, `game_over`=0, `winner`=00, `move_count`=0, `play` history register=0.
- States and transitions:
  - IDLE: on a `play` rising edge (`play`=1 and previous sample 0), latch `position` and go to CHECK.
  - CHECK: if the latched position is outside 1..9, or the addressed cell is not 00, go to REJECT; otherwise go to WRITE.
  - REJECT: `illegal_move`=1 for this cycle only. `XO_turn` and `move_count` are unchanged. Next state is IDLE.
  - WRITE: `ply_En_pos` = one-hot of the latched position for this cycle only; `illegal_move`=0. `move_count` increments. Next state is EVAL.
  - EVAL: the bank now shows the new cell. Check the 8 lines (123, 456, 789, 147, 258, 369, 159, 357).
    - If a line has three equal cells of 01 or 10: `winner` = that code, `game_over`=1, go to DONE.
    - Else if `move_count`==9: `winner`=11, `game_over`=1, go to DONE.
    - Else toggle `XO_turn` and go to IDLE.
  - DONE: terminal state. Only `reset` exits it.
- `ply_En_pos` and `illegal_move` are never asserted together. Both are 0 in every state except WRITE and REJECT respectively.
- `play` rising edges outside IDLE are dropped, not queued. The history register keeps updating every cycle, so a held-high `play` never retriggers a move.
- `move_count` saturates at 9; it cannot exceed 9 because DONE is entered first.
- A cell value of 11 appearing on a line is never reported as a win.

## Timing
- Let N be the cycle in which `play` is first sampled high while in IDLE.
  - N+1: CHECK.
  - N+2: either `ply_En_pos` or `illegal_move` is high.
  - N+3: EVAL (write path only).
  - N+4: toggled `XO_turn`, or `game_over`/`winner`, is visible.
- Minimum spacing between accepted moves: 4 cycles of busy time, plus `play` must return low for at least 1 cycle.
- Reset asserted in any state: all outputs take their reset values at the next edge. A pending WRITE is abandoned; the bank clears on the same edge.
- All outputs are registered; none depend combinationally on the inputs.

## Structure
- Shared package `tictactoe_pkg` holds:
  - cell codes `CELL_EMPTY`, `CELL_X`, `CELL_O`;
  - winner codes `WIN_NONE`, `WIN_X`, `WIN_O`, `WIN_DRAW`;
  - the state enum;
  - the 8-entry win-line index table.
- One sub-module, `win_checker`: purely combinational; takes 9 cells and returns a 2-bit line winner. It is reused later by the display logic.

## Test plan
- After reset, `play` with `position`=5 -> `ply_En_pos`=9'b000010000 at N+2; `XO_turn` goes 1->0 at N+4; `move_count`=1.
- Replay square 5 -> `illegal_move`=1 for exactly one cycle; `ply_En_pos`=0; `XO_turn` and `move_count` unchanged.
- `position`=0, then `position`=12 -> each gives a single `illegal_move` pulse and no write.
- Moves X1, O4, X2, O5, X3 -> after X3's EVAL, `winner`=01 and `game_over`=1; a further `play` is ignored and `ply_En_pos` stays 0.
- Nine-move draw sequence 1, 2, 3, 5, 4, 6, 8, 7, 9 -> `winner`=11, `move_count`=9.
- `play` held high for 20 cycles -> exactly one move; `reset` pulsed during WRITE -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared codes, state encoding and win-line table
// for the tic-tac-toe datapath.
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REJECT,
    S_WRITE,
    S_EVAL,
    S_DONE
  } state_t;

  // zero-based square indices, row-major
  localparam int unsigned WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/move_controller_win_checker.sv
// Combinational line evaluator: reports X or O when
// any of the eight lines holds three equal marks.
module win_checker
  import tictactoe_pkg::*;
(
  input  logic [8:0][1:0] cells_i,
  output logic [1:0]      winner_o
);

  logic [7:0] x_line;
  logic [7:0] o_line;

  always_comb begin
    x_line = '0;
    o_line = '0;
    for (int i = 0; i < 8; i++) begin
      x_line[i] = (cells_i[WIN_LINES[i][0]] == CELL_X)
               && (cells_i[WIN_LINES[i][1]] == CELL_X)
               && (cells_i[WIN_LINES[i][2]] == CELL_X);
      o_line[i] = (cells_i[WIN_LINES[i][0]] == CELL_O)
               && (cells_i[WIN_LINES[i][1]] == CELL_O)
               && (cells_i[WIN_LINES[i][2]] == CELL_O);
    end
    winner_o = WIN_NONE;
    if (|x_line)      winner_o = WIN_X;
    else if (|o_line) winner_o = WIN_O;
  end

endmodule

// File: rtl/move_controller.sv
// Turn sequencer and move validator: checks a requested
// square, pulses a write or a reject, then scores the board.
module move_controller
  import tictactoe_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic [3:0] position,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [8:0] ply_En_pos,
  output logic       illegal_move,
  output logic       XO_turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count
);

  state_t          state_q, state_d;
  logic            play_q;
  logic [3:0]      pos_q;
  logic [8:0][1:0] cells;
  logic [1:0]      sel_cell;
  logic [8:0]      onehot;
  logic [1:0]      line_win;
  logic            rise;
  logic            legal;

  logic [8:0] ply_q, ply_d;
  logic       ill_q, ill_d;
  logic       xo_q, xo_d;
  logic       over_q, over_d;
  logic [1:0] win_q, win_d;
  logic [3:0] cnt_q, cnt_d;

  assign cells = {pos9, pos8, pos7, pos6, pos5,
                  pos4, pos3, pos2, pos1};
  assign rise  = play & ~play_q;

  win_checker u_win (
    .cells_i  (cells),
    .winner_o (line_win)
  );

  // out-of-range squares fall through as occupied
  always_comb begin
    sel_cell = CELL_O;
    onehot   = '0;
    for (int k = 0; k < 9; k++) begin
      if (pos_q == 4'(k + 1)) begin
        sel_cell  = cells[k];
        onehot[k] = 1'b1;
      end
    end
  end

  assign legal = (sel_cell == CELL_EMPTY);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      play_q  <= 1'b0;
      pos_q   <= '0;
      ply_q   <= '0;
      ill_q   <= 1'b0;
      xo_q    <= 1'b1;
      over_q  <= 1'b0;
      win_q   <= WIN_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      play_q  <= play;
      if (state_q == S_IDLE && rise) pos_q <= position;
      ply_q   <= ply_d;
      ill_q   <= ill_d;
      xo_q    <= xo_d;
      over_q  <= over_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rise) state_d = S_CHECK;
      S_CHECK:  state_d = legal ? S_WRITE : S_REJECT;
      S_REJECT: state_d = S_IDLE;
      S_WRITE:  state_d = S_EVAL;
      S_EVAL: begin
        if (line_win != WIN_NONE || cnt_q == MAX_MOVES)
          state_d = S_DONE;
        else
          state_d = S_IDLE;
      end
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // outputs are registered from the state being entered
  always_comb begin
    ply_d  = (state_d == S_WRITE) ? onehot : '0;
    ill_d  = (state_d == S_REJECT);
    xo_d   = xo_q;
    over_d = over_q;
    win_d  = win_q;
    cnt_d  = cnt_q;
    if (state_d == S_WRITE && cnt_q < MAX_MOVES)
      cnt_d = cnt_q + 4'd1;
    if (state_q == S_EVAL) begin
      if (state_d == S_IDLE) begin
        xo_d = ~xo_q;
      end else begin
        over_d = 1'b1;
        win_d  = (line_win != WIN_NONE) ? line_win : WIN_DRAW;
      end
    end
  end

  assign ply_En_pos   = ply_q;
  assign illegal_move = ill_q;
  assign XO_turn      = xo_q;
  assign game_over    = over_q;
  assign winner       = win_q;
  assign move_count   = cnt_q;

endmodule

// File: tb/tb_move_controller.sv
// Randomized self-checking bench with a behavioural
// game model and a modelled position register bank.
module tb_move_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic [3:0] position = '0;
  logic [1:0] bank [9];
  logic [8:0] ply_En_pos;
  logic       illegal_move;
  logic       XO_turn;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] move_count;
  logic       inj_en = 1'b0;
  int         inj_idx = 0;

  int n_cmp = 0;
  int n_bad = 0;

  int board [9];
  int m_turn;
  int m_cnt;
  int m_over;
  int m_win;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) bank[k] <= 2'b00;
    end else begin
      for (int k = 0; k < 9; k++)
        if (ply_En_pos[k]) bank[k] <= XO_turn ? 2'b01 : 2'b10;
      if (inj_en) bank[inj_idx] <= 2'b11;
    end
  end

  move_controller dut (
    .clock        (clock),
    .reset        (reset),
    .play         (play),
    .position     (position),
    .pos1         (bank[0]),
    .pos2         (bank[1]),
    .pos3         (bank[2]),
    .pos4         (bank[3]),
    .pos5         (bank[4]),
    .pos6         (bank[5]),
    .pos7         (bank[6]),
    .pos8         (bank[7]),
    .pos9         (bank[8]),
    .ply_En_pos   (ply_En_pos),
    .illegal_move (illegal_move),
    .XO_turn      (XO_turn),
    .game_over    (game_over),
    .winner       (winner),
    .move_count   (move_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_win();
    int L [8][3];
    int a, b, c;
    L = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int i = 0; i < 8; i++) begin
      a = board[L[i][0]];
      b = board[L[i][1]];
      c = board[L[i][2]];
      if (a == b && b == c && (a == 1 || a == 2)) return a;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) board[k] = 0;
    m_turn = 1;
    m_cnt  = 0;
    m_over = 0;
    m_win  = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".turn"}, int'(XO_turn), m_turn);
    chk({tag, ".over"}, int'(game_over), m_over);
    chk({tag, ".win"}, int'(winner), m_win);
    chk({tag, ".cnt"}, int'(move_count), m_cnt);
    chk({tag, ".ply"}, int'(ply_En_pos), 0);
    chk({tag, ".ill"}, int'(illegal_move), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    play  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  task automatic do_move(input int p, input int hold);
    int legal;
    int oh;
    int w;
    legal = 0;
    oh    = 0;
    if (!m_over && p >= 1 && p <= 9)
      if (board[p-1] == 0) begin
        legal = 1;
        oh    = 1 << (p - 1);
      end
    @(negedge clock);
    play     = 1'b1;
    position = 4'(p);
    @(negedge clock);
    chk("chk.ply", int'(ply_En_pos), 0);
    chk("chk.ill", int'(illegal_move), 0);
    @(negedge clock);
    chk("pulse.ply", int'(ply_En_pos), oh);
    chk("pulse.ill", int'(illegal_move), (!m_over && !legal) ? 1 : 0);
    if (legal) begin
      board[p-1] = m_turn ? 1 : 2;
      m_cnt++;
    end
    @(negedge clock);
    chk("post.ply", int'(ply_En_pos), 0);
    chk("post.ill", int'(illegal_move), 0);
    @(negedge clock);
    if (legal) begin
      w = model_win();
      if (w != 0) begin
        m_win  = w;
        m_over = 1;
      end else if (m_cnt == 9) begin
        m_win  = 3;
        m_over = 1;
      end else begin
        m_turn = 1 - m_turn;
      end
    end
    check_all("mv");
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold.ply", int'(ply_En_pos), 0);
      chk("hold.ill", int'(illegal_move), 0);
    end
    @(negedge clock);
    play = 1'b0;
  endtask

  task automatic inject(input int idx);
    @(negedge clock);
    inj_en  = 1'b1;
    inj_idx = idx;
    @(negedge clock);
    inj_en  = 1'b0;
    board[idx] = 3;
  endtask

  task automatic reset_in_write(input int p);
    @(negedge clock);
    play     = 1'b1;
    position = 4'(p);
    @(negedge clock);
    @(negedge clock);
    chk("rw.ply", int'(ply_En_pos), 1 << (p - 1));
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    check_all("rw");
    chk("rw.bank", int'(bank[p-1]), 0);
    reset = 1'b0;
    play  = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int seq [9];
    int p;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    check_all("init");

    do_move(5, 0);
    chk("first.cnt", int'(move_count), 1);
    do_move(5, 0);
    do_move(0, 0);
    do_move(12, 0);

    do_reset();
    seq = '{1, 4, 2, 5, 3, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) do_move(seq[i], 0);
    chk("xwin.win", int'(winner), 1);
    do_move(6, 2);

    do_reset();
    seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    for (int i = 0; i < 9; i++) do_move(seq[i], 0);
    chk("draw.win", int'(winner), 3);
    chk("draw.cnt", int'(move_count), 9);

    do_reset();
    do_move(3, 20);
    reset_in_write(7);

    do_reset();
    inject(6);
    inject(7);
    inject(8);
    do_move(8, 0);
    for (int i = 0; i < 30 && !m_over; i++)
      do_move($urandom_range(1, 9), 0);

    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int i = 0; i < 40 && !m_over; i++) begin
        if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 15);
        else p = $urandom_range(1, 9);
        do_move(p, $urandom_range(0, 2));
      end
      do_move($urandom_range(1, 9), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
